des_key_sched: RTL and testbench

- Sequential DES key-schedule generator. Accepts one 64-bit key and emits the sixteen 48-bit round subkeys in order, one per accepted handshake, to the downstream round datapath.
- Holds the 28-bit C/D halves in registers. Each step applies the per-round circular rotation (1 or 2 bits) followed by PC-2.
- Supports encrypt order (K1..K16) and decrypt order (K16..K1).

---
 rtl/des_key_sched.sv | 138 +++++++++++++
 tb/tb_des_key_sched.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/des_key_sched.sv
// DES key-schedule generator: loads one 64-bit key and streams the sixteen 48-bit
// round subkeys over a valid/ready handshake, in encrypt or decrypt order.
module des_key_sched (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [63:0] key,
  input  logic        decrypt,
  output logic        ready,
  output logic        k_valid,
  input  logic        k_ready,
  output logic [3:0]  k_round,
  output logic [47:0] k_out,
  output logic        done
);

  typedef enum logic {IDLE, RUN} state_e;

  // FIPS 46-3 tables, 1-based DES bit numbers (bit 1 is the MSB of the source vector).
  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

  function automatic logic [55:0] pc1(input logic [63:0] k);
    logic [55:0] r;
    r = '0;
    for (int i = 0; i < 56; i++) r[55-i] = k[64-PC1[i]];
    return r;
  endfunction

  function automatic logic [47:0] pc2(input logic [55:0] cd);
    logic [47:0] r;
    r = '0;
    for (int i = 0; i < 48; i++) r[47-i] = cd[56-PC2[i]];
    return r;
  endfunction

  // Decrypt walks the encrypt schedule backwards, so its round 0 needs no shift.
  function automatic logic [1:0] rot_amt(input logic dec, input logic [3:0] idx);
    logic one;
    one = (idx == 4'd0) || (idx == 4'd1) || (idx == 4'd8) || (idx == 4'd15);
    if (dec && idx == 4'd0) return 2'd0;
    return one ? 2'd1 : 2'd2;
  endfunction

  function automatic logic [27:0] rot(input logic [27:0] x, input logic dec,
                                      input logic [3:0] idx);
    logic [1:0] a;
    a = rot_amt(dec, idx);
    if (!dec) return (a == 2'd1) ? {x[26:0], x[27]} : {x[25:0], x[27:26]};
    case (a)
      2'd0:    return x;
      2'd1:    return {x[0], x[27:1]};
      default: return {x[1:0], x[27:2]};
    endcase
  endfunction

  state_e      state_q;
  logic [27:0] c_q, c_d;
  logic [27:0] d_q, d_d;
  logic        dir_q;
  logic [3:0]  k_round_q;
  logic        k_valid_q;
  logic        done_q;
  logic [55:0] key_cd;
  logic        last_round;

  assign last_round = (k_round_q == 4'd15);

  // NOTE: every output of this block gets a default first, otherwise the hold paths infer latches.
  always_comb begin
    key_cd = pc1(key);
    c_d    = c_q;
    d_d    = d_q;
    if (state_q == IDLE && start) begin
      c_d = rot(key_cd[55:28], decrypt, 4'd0);
      d_d = rot(key_cd[27:0],  decrypt, 4'd0);
    end else if (state_q == RUN && k_ready && !last_round) begin
      c_d = rot(c_q, dir_q, k_round_q + 4'd1);
      d_d = rot(d_q, dir_q, k_round_q + 4'd1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      c_q       <= '0;
      d_q       <= '0;
      dir_q     <= 1'b0;
      k_round_q <= '0;
      k_valid_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      c_q    <= c_d;
      d_q    <= d_d;
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            dir_q     <= decrypt;
            k_round_q <= '0;
            k_valid_q <= 1'b1;
            state_q   <= RUN;
          end
        end
        RUN: begin
          if (k_ready) begin
            if (last_round) begin
              state_q   <= IDLE;
              k_valid_q <= 1'b0;
              k_round_q <= '0;
              done_q    <= 1'b1;
            end else begin
              k_round_q <= k_round_q + 4'd1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ready   = (state_q == IDLE);
  assign k_valid = k_valid_q;
  assign k_round = k_round_q;
  assign done    = done_q;
  assign k_out   = k_valid_q ? pc2({c_q, d_q}) : 48'd0;

endmodule

// File: tb/tb_des_key_sched.sv
// Self-checking bench for des_key_sched: textbook DES key-schedule model with
// directed, backpressured, randomized and reset scenarios.
module tb_des_key_sched;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [63:0] key;
  logic        decrypt;
  logic        ready;
  logic        k_valid;
  logic        k_ready;
  logic [3:0]  k_round;
  logic [47:0] k_out;
  logic        done;

  int errors = 0;
  int checks = 0;

  logic [47:0] exp_k   [16];
  logic [47:0] cap     [16];
  logic [47:0] enc_cap [16];

  localparam logic [63:0] KEY_REF = 64'h133457799BBCDFF1;

  localparam int T_PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
  localparam int T_PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
  localparam int T_SHIFT [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  des_key_sched dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .key     (key),
    .decrypt (decrypt),
    .ready   (ready),
    .k_valid (k_valid),
    .k_ready (k_ready),
    .k_round (k_round),
    .k_out   (k_out),
    .done    (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Textbook schedule on 1-based bit arrays: always shift left, decrypt just reverses the list.
  task automatic model(input logic [63:0] k, input bit dec);
    bit          kb [65];
    bit          cd [57];
    bit          t;
    logic [47:0] ks [16];
    for (int n = 1; n <= 64; n++) kb[n] = k[64-n];
    for (int j = 1; j <= 56; j++) cd[j] = kb[T_PC1[j-1]];
    for (int r = 0; r < 16; r++) begin
      for (int s = 0; s < T_SHIFT[r]; s++) begin
        t = cd[1];
        for (int j = 1; j < 28; j++) cd[j] = cd[j+1];
        cd[28] = t;
        t = cd[29];
        for (int j = 29; j < 56; j++) cd[j] = cd[j+1];
        cd[56] = t;
      end
      ks[r] = '0;
      for (int j = 1; j <= 48; j++) ks[r][48-j] = cd[T_PC2[j-1]];
    end
    for (int i = 0; i < 16; i++) exp_k[i] = dec ? ks[15-i] : ks[i];
  endtask

  // Entered and left at 1 time unit after a rising edge; leaves the bench in the done cycle.
  task automatic run_seq(input logic [63:0] k, input bit dec, input bit bp, input bit poke);
    int idx    = 0;
    int budget = 0;
    bit poked  = 0;
    model(k, dec);
    check("ready_before_start", ready, 1);
    start   = 1'b1;
    key     = k;
    decrypt = dec;
    k_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("latency_valid", k_valid, 1);
    check("busy_not_ready", ready, 0);
    while (idx < 16 && budget < 400) begin
      budget++;
      k_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (poke && idx == 5 && !poked) begin
        start   = 1'b1;
        key     = ~k;
        decrypt = ~dec;
        poked   = 1'b1;
      end else begin
        start = 1'b0;
      end
      check("valid", k_valid, 1);
      check("round", k_round, idx);
      check("subkey", k_out, exp_k[idx]);
      check("no_early_done", done, 0);
      cap[idx] = k_out;
      if (k_ready) idx++;
      @(posedge clk); #1;
    end
    start   = 1'b0;
    k_ready = 1'b1;
    check("seq_len", idx, 16);
    check("done_pulse", done, 1);
    check("valid_dropped", k_valid, 0);
    check("ready_in_done", ready, 1);
    check("kout_zero_idle", k_out, 0);
    check("round_cleared", k_round, 0);
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
    check("done_one_cycle", done, 0);
    check("idle_ready", ready, 1);
    check("idle_valid", k_valid, 0);
  endtask

  initial begin
    int n;
    logic [63:0] rk;
    rst_n   = 1'b0;
    start   = 1'b0;
    key     = '0;
    decrypt = 1'b0;
    k_ready = 1'b1;
    #12;
    check("rst_ready", ready, 1);
    check("rst_valid", k_valid, 0);
    check("rst_kout", k_out, 0);
    check("rst_round", k_round, 0);
    check("rst_done", done, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Reference key, encrypt order, known endpoints.
    run_seq(KEY_REF, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) enc_cap[i] = cap[i];
    check("enc_k1", enc_cap[0], 48'h1B02EFFC7072);
    check("enc_k16", enc_cap[15], 48'hCB3D8B0E17F5);
    idle_cycle();

    // Decrypt order is the exact reverse.
    run_seq(KEY_REF, 1'b1, 1'b0, 1'b0);
    check("dec_first", cap[0], 48'hCB3D8B0E17F5);
    check("dec_last", cap[15], 48'h1B02EFFC7072);
    for (int i = 0; i < 16; i++) check("dec_reverse", cap[i], enc_cap[15-i]);
    idle_cycle();

    // Random backpressure must not change the sequence.
    run_seq(KEY_REF, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) check("bp_same_seq", cap[i], enc_cap[i]);
    idle_cycle();

    // Parity bits are ignored.
    run_seq(KEY_REF ^ 64'h0101010101010101, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) check("parity_inv", cap[i], enc_cap[i]);
    idle_cycle();

    // Zero key gives zero subkeys.
    run_seq(64'd0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) check("zero_key", cap[i], 0);
    idle_cycle();

    // Start during RUN with another key is ignored.
    run_seq(KEY_REF, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) check("start_in_run", cap[i], enc_cap[i]);

    // Start in the done cycle: back-to-back random keys.
    for (int r = 0; r < 4; r++) begin
      rk = {$urandom, $urandom};
      run_seq(rk, 1'($urandom_range(0, 1)), 1'b1, 1'b0);
    end
    idle_cycle();

    // Asynchronous reset mid-sequence at round 7.
    start   = 1'b1;
    key     = KEY_REF;
    decrypt = 1'b0;
    k_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (k_round != 4'd7 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("reach_round7", k_round, 7);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", k_valid, 0);
    check("arst_kout", k_out, 0);
    check("arst_ready", ready, 1);
    check("arst_done", done, 0);
    check("arst_round", k_round, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("post_rst_no_done", done, 0);
      check("post_rst_valid", k_valid, 0);
    end
    run_seq(KEY_REF, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) check("post_rst_seq", cap[i], enc_cap[15-i]);
    idle_cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
